fetch_stage: RTL and testbench

//  F stage of the 5-stage MIPS pipeline: owns the PC register, drives instruction-memory

---
 rtl/fetch_stage_pkg.sv | 19 +
 rtl/fetch_stage_if_id_reg.sv | 55 +++++
 rtl/fetch_stage.sv | 117 +++++++++++
 tb/tb_fetch_stage.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared constants, FSM state type and fetch-address check for the MIPS F stage.
package fetch_stage_pkg;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_3000;
  localparam logic [31:0] NOP              = 32'h0000_0000;

  typedef enum logic {
    F_FETCH = 1'b0,
    F_HOLD  = 1'b1
  } fstate_e;

  // The upper bound is 33 bits so that a window ending at 2^32 still compares correctly.
  function automatic logic addr_error(input logic [31:0] pc,
                                      input logic [31:0] base,
                                      input logic [32:0] limit);
    return (pc[1:0] != 2'b00) || ({1'b0, pc} < {1'b0, base}) || ({1'b0, pc} >= limit);
  endfunction

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: hold on stall, bubble on clear or idle, load on advance.
module fetch_stage_if_id_reg
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        hold_i,
  input  logic        clear_i,
  input  logic        load_i,
  input  logic [31:0] instr_i,
  input  logic [31:0] pc_i,
  input  logic        adel_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  output logic        valid_o,
  output logic        adel_o
);

  logic [31:0] instr_q;
  logic [31:0] pc_q;
  logic        valid_q;
  logic        adel_q;

  // A bubble keeps the last PC; only instruction, valid and exception bits are cleared.
  always_ff @(posedge clk) begin
    if (reset) begin
      instr_q <= NOP;
      pc_q    <= RESET_PC;
      valid_q <= 1'b0;
      adel_q  <= 1'b0;
    end else if (hold_i) begin
      instr_q <= instr_q;
      pc_q    <= pc_q;
      valid_q <= valid_q;
      adel_q  <= adel_q;
    end else if (load_i && !clear_i) begin
      instr_q <= instr_i;
      pc_q    <= pc_i;
      valid_q <= 1'b1;
      adel_q  <= adel_i;
    end else begin
      instr_q <= NOP;
      valid_q <= 1'b0;
      adel_q  <= 1'b0;
    end
  end

  assign instr_o = instr_q;
  assign pc_o    = pc_q;
  assign valid_o = valid_q;
  assign adel_o  = adel_q;

endmodule

// File: rtl/fetch_stage.sv
// MIPS F stage: PC register, imem req/ready handshake, delayed-branch redirect latch,
// stall hold buffer and the IF/ID register.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter logic [31:0] IM_BASE  = 32'h0000_3000,
  parameter int          IM_WORDS = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        branch,
  input  logic [31:0] npc,
  input  logic        d_clear,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  output logic [31:0] F_pc,
  output logic [31:0] D_instr,
  output logic [31:0] D_pc,
  output logic [31:0] D_pc8,
  output logic        D_valid,
  output logic        D_exc_adel
);

  localparam logic [32:0] IM_END = {1'b0, IM_BASE} + (33'(IM_WORDS) * 33'd4);

  fstate_e     state_q, state_d;
  logic [31:0] fpc_q, fpc_d;
  logic [31:0] redir_pc_q, redir_pc_d;
  logic        redir_pend_q, redir_pend_d;
  logic [31:0] hold_instr_q, hold_instr_d;
  logic        hold_adel_q, hold_adel_d;

  logic        adel;
  logic        take_branch;
  logic        done;
  logic        advance;
  logic [31:0] adv_instr;
  logic        adv_adel;

  // A bad fetch address completes immediately with a nop and never reaches imem.
  assign adel        = addr_error(fpc_q, IM_BASE, IM_END);
  assign take_branch = branch & ~stall;
  assign done        = (state_q == F_FETCH) & (imem_ready | adel);
  assign advance     = ~stall & (done | (state_q == F_HOLD));
  assign adv_instr   = (state_q == F_HOLD) ? hold_instr_q : (adel ? NOP : imem_rdata);
  assign adv_adel    = (state_q == F_HOLD) ? hold_adel_q : adel;

  always_comb begin
    state_d      = state_q;
    fpc_d        = fpc_q;
    redir_pc_d   = redir_pc_q;
    redir_pend_d = redir_pend_q;
    hold_instr_d = hold_instr_q;
    hold_adel_d  = hold_adel_q;
    if (advance) begin
      state_d      = F_FETCH;
      redir_pend_d = 1'b0;
      if (take_branch)       fpc_d = npc;
      else if (redir_pend_q) fpc_d = redir_pc_q;
      else                   fpc_d = fpc_q + 32'd4;
    end else if (take_branch) begin
      redir_pc_d   = npc;
      redir_pend_d = 1'b1;
    end
    // A word returned under stall is parked so it is never refetched or lost.
    if (done && stall) begin
      state_d      = F_HOLD;
      hold_instr_d = adel ? NOP : imem_rdata;
      hold_adel_d  = adel;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= F_FETCH;
      fpc_q        <= RESET_PC;
      redir_pc_q   <= RESET_PC;
      redir_pend_q <= 1'b0;
      hold_instr_q <= NOP;
      hold_adel_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      fpc_q        <= fpc_d;
      redir_pc_q   <= redir_pc_d;
      redir_pend_q <= redir_pend_d;
      hold_instr_q <= hold_instr_d;
      hold_adel_q  <= hold_adel_d;
    end
  end

  fetch_stage_if_id_reg #(
    .RESET_PC(RESET_PC)
  ) u_if_id (
    .clk    (clk),
    .reset  (reset),
    .hold_i (stall),
    .clear_i(d_clear),
    .load_i (advance),
    .instr_i(adv_instr),
    .pc_i   (fpc_q),
    .adel_i (adv_adel),
    .instr_o(D_instr),
    .pc_o   (D_pc),
    .valid_o(D_valid),
    .adel_o (D_exc_adel)
  );

  assign imem_req  = (state_q == F_FETCH) & ~adel;
  assign imem_addr = fpc_q;
  assign F_pc      = fpc_q;
  assign D_pc8     = D_pc + 32'd8;

endmodule

// File: tb/tb_fetch_stage.sv
// Randomized self-checking bench for fetch_stage against a transaction-level fetch model.
module tb_fetch_stage;

  localparam logic [31:0] RPC   = 32'h0000_3000;
  localparam logic [31:0] BASE  = 32'h0000_3000;
  localparam int          WORDS = 4096;

  logic        clk = 1'b0;
  logic        reset, stall, branch, d_clear, imem_ready;
  logic [31:0] npc, imem_rdata;
  logic        imem_req;
  logic [31:0] imem_addr, F_pc, D_instr, D_pc, D_pc8;
  logic        D_valid, D_exc_adel;

  int total = 0;
  int bad   = 0;

  logic [31:0] mPc, mTarget, mWord, mDinstr, mDpc;
  bit          mPend, mHave, mWordAdel, mDvalid, mDadel;

  fetch_stage #(
    .RESET_PC(RPC),
    .IM_BASE (BASE),
    .IM_WORDS(WORDS)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .stall     (stall),
    .branch    (branch),
    .npc       (npc),
    .d_clear   (d_clear),
    .imem_req  (imem_req),
    .imem_addr (imem_addr),
    .imem_rdata(imem_rdata),
    .imem_ready(imem_ready),
    .F_pc      (F_pc),
    .D_instr   (D_instr),
    .D_pc      (D_pc),
    .D_pc8     (D_pc8),
    .D_valid   (D_valid),
    .D_exc_adel(D_exc_adel)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC3A5_0F01;
  endfunction

  function automatic bit legalPc(input logic [31:0] a);
    longint x;
    longint lo;
    x  = longint'(a);
    lo = longint'(BASE);
    return (a[1:0] == 2'b00) && (x >= lo) && (x < lo + 4 * WORDS);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic modelReset();
    mPc     = RPC;
    mTarget = RPC;
    mPend   = 0;
    mHave   = 0;
    mDinstr = 32'h0;
    mDpc    = RPC;
    mDvalid = 0;
    mDadel  = 0;
  endtask

  // One clock cycle: drive, check request side, clock, update model, check IF/ID side.
  task automatic applyStimulus(input bit rst, input bit stl, input bit br,
                               input logic [31:0] np, input bit clr, input bit rdy);
    bit          legal, wordReady, wadel;
    logic [31:0] word, nextPc;
    legal      = legalPc(mPc);
    reset      = rst;
    stall      = stl;
    branch     = br;
    npc        = br ? np : $urandom;
    d_clear    = clr;
    imem_ready = rdy;
    imem_rdata = (!mHave && legal && rdy) ? memWord(mPc) : $urandom;
    #1;
    if (!rst) begin
      checkOutput("imem_req", {31'b0, imem_req}, {31'b0, (!mHave && legal)});
      checkOutput("imem_addr", imem_addr, mPc);
    end
    @(posedge clk);
    if (rst) begin
      modelReset();
    end else begin
      wordReady = mHave || !legal || rdy;
      word      = mHave ? mWord : (legal ? memWord(mPc) : 32'h0);
      wadel     = mHave ? mWordAdel : !legal;
      if (stl) begin
        if (!mHave && wordReady) begin
          mHave     = 1;
          mWord     = word;
          mWordAdel = wadel;
        end
      end else if (wordReady) begin
        nextPc = br ? np : (mPend ? mTarget : mPc + 32'd4);
        if (clr) begin
          mDinstr = 32'h0;
          mDvalid = 0;
          mDadel  = 0;
        end else begin
          mDinstr = word;
          mDpc    = mPc;
          mDvalid = 1;
          mDadel  = wadel;
        end
        mPc   = nextPc;
        mPend = 0;
        mHave = 0;
      end else begin
        if (br) begin
          mPend   = 1;
          mTarget = np;
        end
        mDinstr = 32'h0;
        mDvalid = 0;
        mDadel  = 0;
      end
    end
    #1;
    checkOutput("F_pc", F_pc, mPc);
    checkOutput("D_instr", D_instr, mDinstr);
    checkOutput("D_pc", D_pc, mDpc);
    checkOutput("D_pc8", D_pc8, mDpc + 32'd8);
    checkOutput("D_valid", {31'b0, D_valid}, {31'b0, mDvalid});
    checkOutput("D_exc_adel", {31'b0, D_exc_adel}, {31'b0, mDadel});
  endtask

  function automatic logic [31:0] randTarget();
    int k;
    k = $urandom_range(0, 9);
    case (k)
      0:       return 32'h0000_3002 + 32'($urandom_range(0, 100) * 4);
      1:       return 32'h0000_2FFC;
      2:       return 32'h0000_7000;
      3:       return 32'hFFFF_FFF8 + 32'($urandom_range(0, 1) * 4);
      default: return BASE + 32'($urandom_range(0, WORDS - 1) * 4);
    endcase
  endfunction

  initial begin
    modelReset();
    applyStimulus(1, 0, 0, 0, 0, 1);
    applyStimulus(1, 0, 0, 0, 0, 1);
    // Zero-wait streaming, then a taken branch with its delay slot.
    applyStimulus(0, 0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 1);
    applyStimulus(0, 0, 1, 32'h0000_3100, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 1);
    // Slow imem with a redirect arriving while the delay slot is outstanding.
    applyStimulus(0, 0, 1, 32'h0000_3200, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 1);
    // Word returns under stall, buffered, then released without refetch.
    applyStimulus(0, 1, 0, 0, 0, 1);
    applyStimulus(0, 1, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 0);
    // d_clear alone, then together with stall.
    applyStimulus(0, 0, 0, 0, 1, 1);
    applyStimulus(0, 1, 0, 0, 1, 1);
    applyStimulus(0, 0, 0, 0, 0, 1);
    // Address errors: misaligned, below base, and wrap past 2^32.
    applyStimulus(0, 0, 1, 32'h0000_3002, 0, 1);
    applyStimulus(0, 0, 1, 32'h0000_2FFC, 0, 0);
    applyStimulus(0, 0, 1, 32'hFFFF_FFFC, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    // Reset while a redirect is pending.
    applyStimulus(0, 0, 1, 32'h0000_3300, 0, 1);
    applyStimulus(0, 0, 1, 32'h0000_3400, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 1);

    for (int i = 0; i < 3000; i++) begin
      applyStimulus($urandom_range(0, 199) == 0,
                    $urandom_range(0, 3) == 0,
                    $urandom_range(0, 6) == 0,
                    randTarget(),
                    $urandom_range(0, 9) == 0,
                    $urandom_range(0, 4) < 3);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
